// File: rtl/nova_pkg.sv
// -----------------------------------------------------------------------------
// nova_pkg
// Shared constants for the integer register file and the WB->RF write bus.
// WB and EX forwarding use the same field offsets to pack and unpack
// wb2rf_bus = {rf_we, rf_waddr, rf_wdata}.
// Contents:
//   REG_NUM, XLEN, RADDR_W  register file geometry
//   WB2RF_WD                total bus width (1 + RADDR_W + XLEN)
//   WB2RF_*                 bit offsets of the bus fields
//   SB_CNT_W                default width of a pending-write counter
//   wb2rf_t                 packed view of the write bus
// -----------------------------------------------------------------------------
package nova_pkg;

  localparam int REG_NUM         = 32;
  localparam int XLEN            = 64;
  localparam int RADDR_W         = 5;
  localparam int WB2RF_WD        = 1 + RADDR_W + XLEN;
  localparam int WB2RF_WE_BIT    = WB2RF_WD - 1;
  localparam int WB2RF_WADDR_LSB = XLEN;
  localparam int WB2RF_WDATA_LSB = 0;
  localparam int SB_CNT_W        = 3;

  typedef struct packed {
    logic               we;
    logic [RADDR_W-1:0] waddr;
    logic [XLEN-1:0]    wdata;
  } wb2rf_t;

endpackage

// File: rtl/regfile_sb_cnt.sv
// -----------------------------------------------------------------------------
// regfile_sb_cnt
// One saturating up/down pending-write counter of the register scoreboard.
// The net step (inc - dec_c - dec_w) is applied in a single cycle.
// A result above the maximum saturates, a result below zero holds at zero;
// ovf/unf flag that this cycle's update was clipped.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   inc             one instruction issued to this register
//   dec_c           one issued instruction cancelled
//   dec_w           one write-back completed
//   cnt             registered counter value
//   ovf, unf        this cycle's update overflowed / underflowed
// -----------------------------------------------------------------------------
module regfile_sb_cnt
  import nova_pkg::*;
#(
  parameter int CNT_W = SB_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec_c,
  input  logic             dec_w,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);

  // Two guard bits: one for the overflow carry, one as the sign of the result.
  localparam logic [CNT_W+1:0] SUM_MAX = {2'b00, {CNT_W{1'b1}}};

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W+1:0] w_sum;
  logic [CNT_W-1:0] w_nxt;

  // Net step and saturation of the next counter value
  always_comb begin
    w_sum = {2'b00, r_cnt} + {{(CNT_W+1){1'b0}}, inc}
          - {{(CNT_W+1){1'b0}}, dec_c} - {{(CNT_W+1){1'b0}}, dec_w};
    w_nxt = r_cnt;
    ovf   = 1'b0;
    unf   = 1'b0;
    if (w_sum[CNT_W+1]) begin
      unf   = 1'b1;
      w_nxt = {CNT_W{1'b0}};
    end else if (w_sum > SUM_MAX) begin
      ovf   = 1'b1;
      w_nxt = {CNT_W{1'b1}};
    end else begin
      w_nxt = w_sum[CNT_W-1:0];
    end
  end

  // Counter state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else begin
      r_cnt <= w_nxt;
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// regfile_sb
// 32 x 64-bit integer register file with two combinational read ports and a
// per-register pending-write scoreboard used by ID for RAW stall decisions.
// x0 reads as zero and is never written or counted.
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle WB write is forwarded to rs*_data and the final
//               pending write no longer counts as busy.
//   undefined : rs*_data shows only the stored value; busy holds through the
//               WB cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   wb2rf_bus             {rf_we, rf_waddr, rf_wdata} from WB
//   rs1_addr / rs1_data   read port 1
//   rs2_addr / rs2_data   read port 2
//   issue_valid/issue_rd  reg-writing instruction issued by ID
//   cancel_valid/cancel_rd previously issued instruction squashed
//   rs1_busy, rs2_busy    read address has an outstanding write
//   sb_err                sticky scoreboard overflow/underflow flag
// -----------------------------------------------------------------------------
module regfile_sb #(
  parameter int WB2RF_WD = nova_pkg::WB2RF_WD,
  parameter int CNT_W    = nova_pkg::SB_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WB2RF_WD-1:0]          wb2rf_bus,
  input  logic [nova_pkg::RADDR_W-1:0] rs1_addr,
  output logic [nova_pkg::XLEN-1:0]    rs1_data,
  input  logic [nova_pkg::RADDR_W-1:0] rs2_addr,
  output logic [nova_pkg::XLEN-1:0]    rs2_data,
  input  logic                         issue_valid,
  input  logic [nova_pkg::RADDR_W-1:0] issue_rd,
  input  logic                         cancel_valid,
  input  logic [nova_pkg::RADDR_W-1:0] cancel_rd,
  output logic                         rs1_busy,
  output logic                         rs2_busy,
  output logic                         sb_err
);
  import nova_pkg::*;

  localparam logic [RADDR_W-1:0] X0      = {RADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  wb2rf_t             w_wb;
  logic [XLEN-1:0]    r_regs [REG_NUM];
  logic [CNT_W-1:0]   w_cnt  [REG_NUM];
  logic [REG_NUM-1:1] w_inc;
  logic [REG_NUM-1:1] w_dec_c;
  logic [REG_NUM-1:1] w_dec_w;
  logic [REG_NUM-1:1] w_ovf;
  logic [REG_NUM-1:1] w_unf;
  logic               r_sb_err;
  logic [XLEN-1:0]    w_rs1_data;
  logic [XLEN-1:0]    w_rs2_data;
  logic               w_rs1_busy;
  logic               w_rs2_busy;

  assign w_wb     = wb2rf_bus;
  // x0 has no counter; a constant zero keeps busy low for address 0.
  assign w_cnt[0] = {CNT_W{1'b0}};

  // One scoreboard counter per architectural register x1..x31
  for (genvar g = 1; g < REG_NUM; g++) begin : g_cnt
    assign w_inc[g]   = issue_valid  && (issue_rd  == RADDR_W'(g));
    assign w_dec_c[g] = cancel_valid && (cancel_rd == RADDR_W'(g));
    assign w_dec_w[g] = w_wb.we      && (w_wb.waddr == RADDR_W'(g));

    regfile_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_inc[g]),
      .dec_c (w_dec_c[g]),
      .dec_w (w_dec_w[g]),
      .cnt   (w_cnt[g]),
      .ovf   (w_ovf[g]),
      .unf   (w_unf[g])
    );
  end

  // Register array write from WB; writes to x0 are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= {XLEN{1'b0}};
      end
    end else if (w_wb.we && (w_wb.waddr != X0)) begin
      r_regs[w_wb.waddr] <= w_wb.wdata;
    end
  end

  // Sticky scoreboard error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sb_err <= 1'b0;
    end else if ((|w_ovf) || (|w_unf)) begin
      r_sb_err <= 1'b1;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_hit1;
  logic w_hit2;
  // WB is writing the register being read this cycle
  assign w_hit1 = w_wb.we && (w_wb.waddr == rs1_addr);
  assign w_hit2 = w_wb.we && (w_wb.waddr == rs2_addr);
`endif

  // Read port 1: data and busy, forced to zero in reset and for x0
  always_comb begin
    w_rs1_data = {XLEN{1'b0}};
    w_rs1_busy = 1'b0;
    if (rst || (rs1_addr == X0)) begin
      w_rs1_data = {XLEN{1'b0}};
      w_rs1_busy = 1'b0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      if (w_hit1) begin
        w_rs1_data = w_wb.wdata;
      end else begin
        w_rs1_data = r_regs[rs1_addr];
      end
      // The completing write is forwarded, so it is not outstanding.
      w_rs1_busy = (w_cnt[rs1_addr] != {CNT_W{1'b0}})
                && !((w_cnt[rs1_addr] == CNT_ONE) && w_hit1);
`else
      w_rs1_data = r_regs[rs1_addr];
      w_rs1_busy = (w_cnt[rs1_addr] != {CNT_W{1'b0}});
`endif
    end
  end

  // Read port 2: data and busy, forced to zero in reset and for x0
  always_comb begin
    w_rs2_data = {XLEN{1'b0}};
    w_rs2_busy = 1'b0;
    if (rst || (rs2_addr == X0)) begin
      w_rs2_data = {XLEN{1'b0}};
      w_rs2_busy = 1'b0;
    end else begin
`ifdef REGFILE_BYPASS_EN
      if (w_hit2) begin
        w_rs2_data = w_wb.wdata;
      end else begin
        w_rs2_data = r_regs[rs2_addr];
      end
      w_rs2_busy = (w_cnt[rs2_addr] != {CNT_W{1'b0}})
                && !((w_cnt[rs2_addr] == CNT_ONE) && w_hit2);
`else
      w_rs2_data = r_regs[rs2_addr];
      w_rs2_busy = (w_cnt[rs2_addr] != {CNT_W{1'b0}});
`endif
    end
  end

  assign rs1_data = w_rs1_data;
  assign rs2_data = w_rs2_data;
  assign rs1_busy = w_rs1_busy;
  assign rs2_busy = w_rs2_busy;
  assign sb_err   = r_sb_err;

endmodule
